seq_stage_controller: RTL

SEQ_STAGE_CONTROLLER -- requirements
Module: seq_stage_controller

---
 rtl/y86_pkg.sv | 60 ++++++
 rtl/pc_select.sv | 23 ++
 rtl/seq_stage_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: controller state codes, status codes, icode constants
// and stage-strobe helpers used by the sequencer and fetch stage.
package y86_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_DEC   = 3'd2;
  localparam state_t S_EXEC  = 3'd3;
  localparam state_t S_MEM   = 3'd4;
  localparam state_t S_WB    = 3'd5;
  localparam state_t S_PCUPD = 3'd6;
  localparam state_t S_STOP  = 3'd7;

  typedef logic [1:0] stat_t;

  localparam stat_t STAT_AOK = 2'd0;
  localparam stat_t STAT_HLT = 2'd1;
  localparam stat_t STAT_ADR = 2'd2;
  localparam stat_t STAT_INS = 2'd3;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic exec;
    logic mem;
    logic wb;
  } stage_en_t;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
           (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
  endfunction

  function automatic stage_en_t stage_en_of(input state_t s);
    stage_en_t en;
    en        = '0;
    en.fetch  = (s == S_FETCH);
    en.decode = (s == S_DEC);
    en.exec   = (s == S_EXEC);
    en.mem    = (s == S_MEM);
    en.wb     = (s == S_WB);
    return en;
  endfunction

endpackage

// File: rtl/pc_select.sv
// Next-PC mux applied in PCUPD: call/taken jump -> valC, ret -> valM, else valP.
module pc_select
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valc,
  input  logic [63:0] valp,
  input  logic [63:0] valm,
  output logic [63:0] pc_next
);

  always_comb begin
    pc_next = valp;
    case (icode)
      ICALL:   pc_next = valc;
      IJXX:    pc_next = cnd ? valc : valp;
      IRET:    pc_next = valm;
      default: pc_next = valp;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Sequential Y86 stage controller: walks one instruction through the stages,
// owns PC/Stat/retire count, and arbitrates the data-memory handshake.
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [63:0] PC_RESET    = 64'h0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  input  logic [3:0]  icode,
  input  logic        Ins_err,
  input  logic        Adr_err,
  input  logic        Halt,
  input  logic        Cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        Mem_ack,
  input  logic        Mem_err,
  output logic        Fetch_en,
  output logic        Decode_en,
  output logic        Exec_en,
  output logic        Mem_en,
  output logic        Wb_en,
  output logic        Mem_req,
  output logic [63:0] PC,
  output logic [1:0]  Stat,
  output logic        Busy,
  output logic [31:0] Instr_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t         state_q, state_d;
  stat_t          stat_q, stat_d;
  stage_en_t      en_q;
  logic [3:0]     icode_q;
  logic           cnd_q;
  logic [WW-1:0]  wait_q;
  logic           mem_req_q;
  logic           busy_q;
  logic [63:0]    pc_q;
  logic [63:0]    pc_next;
  logic [31:0]    cnt_q;

  pc_select u_pc_select (
    .icode   (icode_q),
    .cnd     (cnd_q),
    .valc    (valC),
    .valp    (valP),
    .valm    (valM),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE:  if (Run) state_d = S_FETCH;
      S_FETCH: begin
        if (Adr_err) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else if (Ins_err) begin
          state_d = S_STOP;
          stat_d  = STAT_INS;
        end else if (Halt) begin
          state_d = S_STOP;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DEC;
        end
      end
      S_DEC:   state_d = S_EXEC;
      S_EXEC:  state_d = S_MEM;
      S_MEM: begin
        // Error beats ack; timeout fires only if the last allowed cycle has no ack.
        if (!is_mem_icode(icode_q)) begin
          state_d = S_WB;
        end else if (Mem_err) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else if (Mem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end
      end
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: state_d = Run ? S_FETCH : S_IDLE;
      S_STOP:  state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      stat_q    <= STAT_AOK;
      en_q      <= '0;
      icode_q   <= INOP;
      cnd_q     <= 1'b0;
      wait_q    <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      pc_q      <= PC_RESET;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      // Outputs are registered from the next state so they line up with it.
      en_q      <= stage_en_of(state_d);
      mem_req_q <= (state_d == S_MEM) && is_mem_icode(icode_q);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_STOP);
      if (state_q == S_FETCH) icode_q <= icode;
      if (state_q == S_EXEC)  cnd_q   <= Cnd;
      if (state_q == S_MEM) wait_q <= wait_q + WW'(1);
      else                  wait_q <= '0;
      if (state_q == S_PCUPD) begin
        pc_q  <= pc_next;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign Fetch_en    = en_q.fetch;
  assign Decode_en   = en_q.decode;
  assign Exec_en     = en_q.exec;
  assign Mem_en      = en_q.mem;
  assign Wb_en       = en_q.wb;
  assign Mem_req     = mem_req_q;
  assign PC          = pc_q;
  assign Stat        = stat_q;
  assign Busy        = busy_q;
  assign Instr_count = cnt_q;

endmodule
